locker_retrieval_ctrl: RTL

//  Retrieval-side controller of the Automated Delivery Locker System: the reader end of the deposit path.

---
 rtl/locker_retrieval_if.sv | 34 +++
 rtl/locker_retrieval_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/locker_retrieval_if.sv
// Store, request and status bundle between the locker retrieval controller and its neighbours.
interface locker_retrieval_if #(
  parameter int unsigned NUM_LOCKERS = 8,
  parameter int unsigned PIN_W       = 4
);
  localparam int unsigned LOCKER_W = $clog2(NUM_LOCKERS);

  logic                   store_valid;
  logic [LOCKER_W-1:0]    store_locker;
  logic [PIN_W-1:0]       store_pin;
  logic                   req_valid;
  logic                   req_ready;
  logic [LOCKER_W-1:0]    req_locker;
  logic [PIN_W-1:0]       req_pin;
  logic [NUM_LOCKERS-1:0] occupied;
  logic [NUM_LOCKERS-1:0] locker_doors;
  logic                   retrieval_auth_led;
  logic                   retrieval_fail_led;
  logic                   lockout_led;
  logic                   release_valid;
  logic [LOCKER_W-1:0]    release_locker;

  modport master (
    output store_valid, store_locker, store_pin, req_valid, req_locker, req_pin,
    input  req_ready, occupied, locker_doors, retrieval_auth_led, retrieval_fail_led,
           lockout_led, release_valid, release_locker
  );

  modport slave (
    input  store_valid, store_locker, store_pin, req_valid, req_locker, req_pin,
    output req_ready, occupied, locker_doors, retrieval_auth_led, retrieval_fail_led,
           lockout_led, release_valid, release_locker
  );
endinterface

// File: rtl/locker_retrieval_ctrl.sv
// Locker retrieval controller: PIN table, pickup authentication, door pulse, release and lockout.
// Optional feature macro: RETRIEVAL_MASTER_PIN_EN (service PIN opens any occupied locker).
module locker_retrieval_ctrl #(
  parameter int unsigned      NUM_LOCKERS    = 8,
  parameter int unsigned      PIN_W          = 4,
  parameter int unsigned      OPEN_CYCLES    = 4,
  parameter int unsigned      MAX_FAILS      = 3,
  parameter int unsigned      LOCKOUT_CYCLES = 16,
  parameter logic [PIN_W-1:0] MASTER_PIN     = 4'hF
) (
  input logic               clk,
  input logic               reset,
  locker_retrieval_if.slave bus
);
  localparam int unsigned LOCKER_W = $clog2(NUM_LOCKERS);
  localparam int unsigned FAIL_W   = $clog2(MAX_FAILS + 1);
  localparam int unsigned OPEN_W   = $clog2(OPEN_CYCLES + 1);
  localparam int unsigned LOCK_W   = $clog2(LOCKOUT_CYCLES + 1);
`ifdef RETRIEVAL_MASTER_PIN_EN
  localparam bit MasterEn = 1'b1;
`else
  localparam bit MasterEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StCheck, StOpen, StLockout} state_e;

  state_e                 state_q;
  logic [PIN_W-1:0]       pin_mem_q [NUM_LOCKERS];
  logic [NUM_LOCKERS-1:0] occupied_q;
  logic [LOCKER_W-1:0]    loc_q;
  logic [PIN_W-1:0]       pin_q;
  logic [FAIL_W-1:0]      fail_cnt_q;
  logic [OPEN_W-1:0]      open_cnt_q;
  logic [LOCK_W-1:0]      lock_cnt_q;
  logic [NUM_LOCKERS-1:0] doors_q;
  logic                   auth_q;
  logic                   fail_led_q;
  logic                   lockout_q;
  logic                   rel_valid_q;
  logic [LOCKER_W-1:0]    rel_locker_q;

  logic                   pin_hit;
  logic                   master_hit;
  logic [FAIL_W-1:0]      fail_next;
  logic [NUM_LOCKERS-1:0] door_mask;

  assign pin_hit    = occupied_q[loc_q] && (pin_mem_q[loc_q] == pin_q);
  assign master_hit = MasterEn && occupied_q[loc_q] && (pin_q == MASTER_PIN);
  assign fail_next  = fail_cnt_q + FAIL_W'(1);
  assign door_mask  = NUM_LOCKERS'(1) << loc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      occupied_q   <= '0;
      loc_q        <= '0;
      pin_q        <= '0;
      fail_cnt_q   <= '0;
      open_cnt_q   <= '0;
      lock_cnt_q   <= '0;
      doors_q      <= '0;
      auth_q       <= 1'b0;
      fail_led_q   <= 1'b0;
      lockout_q    <= 1'b0;
      rel_valid_q  <= 1'b0;
      rel_locker_q <= '0;
      for (int i = 0; i < NUM_LOCKERS; i++) pin_mem_q[i] <= '0;
    end else begin
      fail_led_q  <= 1'b0;
      rel_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            loc_q   <= bus.req_locker;
            pin_q   <= bus.req_pin;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (pin_hit || master_hit) begin
            state_q    <= StOpen;
            open_cnt_q <= OPEN_W'(OPEN_CYCLES);
            // A service-PIN opening leaves the failure history untouched.
            if (pin_hit) fail_cnt_q <= '0;
          end else begin
            fail_led_q <= 1'b1;
            fail_cnt_q <= fail_next;
            if (fail_next == FAIL_W'(MAX_FAILS)) begin
              state_q    <= StLockout;
              lockout_q  <= 1'b1;
              lock_cnt_q <= LOCK_W'(LOCKOUT_CYCLES - 1);
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StOpen: begin
          if (open_cnt_q != '0) begin
            doors_q    <= door_mask;
            auth_q     <= 1'b1;
            open_cnt_q <= open_cnt_q - OPEN_W'(1);
          end else begin
            doors_q           <= '0;
            auth_q            <= 1'b0;
            state_q           <= StIdle;
            rel_valid_q       <= 1'b1;
            rel_locker_q      <= loc_q;
            occupied_q[loc_q] <= 1'b0;
          end
        end
        StLockout: begin
          if (lock_cnt_q == '0) begin
            lockout_q  <= 1'b0;
            fail_cnt_q <= '0;
            state_q    <= StIdle;
          end else begin
            lock_cnt_q <= lock_cnt_q - LOCK_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
      // Placed after the release clear so a same-edge store keeps the locker occupied.
      if (bus.store_valid) begin
        pin_mem_q[bus.store_locker]  <= bus.store_pin;
        occupied_q[bus.store_locker] <= 1'b1;
      end
    end
  end

  assign bus.req_ready          = (state_q == StIdle);
  assign bus.occupied           = occupied_q;
  assign bus.locker_doors       = doors_q;
  assign bus.retrieval_auth_led = auth_q;
  assign bus.retrieval_fail_led = fail_led_q;
  assign bus.lockout_led        = lockout_q;
  assign bus.release_valid      = rel_valid_q;
  assign bus.release_locker     = rel_locker_q;
endmodule
